// File: rtl/tt_gear_pkg.sv
// ---------------------------------------------------------------------------
// tt_gear_pkg
// Shared definitions for the gear status reporter:
//   - 3-bit gear codes reported to the host (GEAR_P .. GEAR_D4, GEAR_INV)
//   - bit positions of each indicator on the 7-bit LED bus
//   - ASCII base added to a gear code to form the transmitted character
//   - serial transmitter state encoding
//   - decode_gear(): one-hot LED pattern -> {code, err}
// ---------------------------------------------------------------------------
package tt_gear_pkg;

    localparam int LED_W  = 7;
    localparam int GEAR_W = 3;

    // Gear codes as reported on the serial line ('0' + code).
    localparam logic [GEAR_W-1:0] GEAR_P   = 3'd0;
    localparam logic [GEAR_W-1:0] GEAR_R   = 3'd1;
    localparam logic [GEAR_W-1:0] GEAR_N   = 3'd2;
    localparam logic [GEAR_W-1:0] GEAR_D1  = 3'd3;
    localparam logic [GEAR_W-1:0] GEAR_D2  = 3'd4;
    localparam logic [GEAR_W-1:0] GEAR_D3  = 3'd5;
    localparam logic [GEAR_W-1:0] GEAR_D4  = 3'd6;
    localparam logic [GEAR_W-1:0] GEAR_INV = 3'd7;

    // Bit positions on the LED bus {R1,N1,P1,D4,D3,D2,D1}.
    localparam int LED_D1 = 0;
    localparam int LED_D2 = 1;
    localparam int LED_D3 = 2;
    localparam int LED_D4 = 3;
    localparam int LED_P1 = 4;
    localparam int LED_N1 = 5;
    localparam int LED_R1 = 6;

    localparam logic [7:0] ASCII_BASE = 8'h30;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [GEAR_W-1:0] code;
        logic              err;
    } gear_dec_t;

    // Exactly one lit indicator maps to its gear; anything else (none lit,
    // several lit) is reported as GEAR_INV with err set.
    function automatic gear_dec_t decode_gear(input logic [LED_W-1:0] led);
        gear_dec_t d;
        d.code = GEAR_INV;
        d.err  = 1'b1;
        case (led)
            7'(1 << LED_P1): begin d.code = GEAR_P;  d.err = 1'b0; end
            7'(1 << LED_R1): begin d.code = GEAR_R;  d.err = 1'b0; end
            7'(1 << LED_N1): begin d.code = GEAR_N;  d.err = 1'b0; end
            7'(1 << LED_D1): begin d.code = GEAR_D1; d.err = 1'b0; end
            7'(1 << LED_D2): begin d.code = GEAR_D2; d.err = 1'b0; end
            7'(1 << LED_D3): begin d.code = GEAR_D3; d.err = 1'b0; end
            7'(1 << LED_D4): begin d.code = GEAR_D4; d.err = 1'b0; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tt_gear_status_tx_if.sv
// ---------------------------------------------------------------------------
// tt_gear_status_tx_if
// Bundles the gear reporter's functional signals.
//   ena       : sampling enable (driver -> reporter)
//   led       : 7-bit gear indicator bus (driver -> reporter)
//   tx        : 8N1 serial line, idle high (reporter -> driver)
//   busy      : frame in progress (reporter -> driver)
//   gear_code : last accepted gear code (reporter -> driver)
//   err       : last accepted pattern was not one-hot (reporter -> driver)
// master = side producing led/ena, slave = the reporter itself.
// ---------------------------------------------------------------------------
interface tt_gear_status_tx_if;
    import tt_gear_pkg::*;

    logic              ena;
    logic [LED_W-1:0]  led;
    logic              tx;
    logic              busy;
    logic [GEAR_W-1:0] gear_code;
    logic              err;

    modport master (output ena, led, input  tx, busy, gear_code, err);
    modport slave  (input  ena, led, output tx, busy, gear_code, err);

endinterface

// File: rtl/tt_uart_tx_8n1.sv
// ---------------------------------------------------------------------------
// tt_uart_tx_8n1
// 8N1 serial transmitter: start bit, 8 data bits LSB first, one stop bit,
// each CLKS_PER_BIT cycles long. A byte offered on start/data while idle, or
// during the last stop-bit cycle, is taken and sent back-to-back.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (aborts a frame)
//   start      : byte available on data; taken when idle or when done=1
//   data[7:0]  : byte to send
//   tx         : serial output, idle high
//   busy       : high from first start-bit cycle to last stop-bit cycle
//   done       : high during the last stop-bit cycle
// ---------------------------------------------------------------------------
module tt_uart_tx_8n1
    import tt_gear_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             load;

    assign bit_end = (clk_cnt == CNT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (start) state_next = TX_START;
            TX_START: if (bit_end) state_next = TX_DATA;
            TX_DATA:  if (bit_end && bit_idx == 3'd7) state_next = TX_STOP;
            TX_STOP:  if (bit_end) state_next = start ? TX_START : TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    // Outputs (Moore on state, plus the load strobe for the shift register).
    always_comb begin
        tx   = 1'b1;
        busy = (state != TX_IDLE);
        done = (state == TX_STOP) && bit_end;
        load = start && ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));
        case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    // Bit timer, bit index and shift register.
    // NOTE: the shift register is reset along with the control state so the
    // datapath never holds X, even though its contents are unused in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == TX_IDLE || bit_end) clk_cnt <= '0;
            else                             clk_cnt <= clk_cnt + CNT_W'(1);

            if (state != TX_DATA) bit_idx <= '0;
            else if (bit_end)     bit_idx <= bit_idx + 3'd1;

            if (load)                          shreg <= data;
            else if (state == TX_DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: rtl/tt_gear_status_tx.sv
// ---------------------------------------------------------------------------
// tt_gear_status_tx
// Gear status reporter. Registers the LED bus, waits for a pattern to hold
// STABLE_CYCLES cycles, decodes it to a gear code and, whenever the accepted
// code changes, sends '0'+code as one 8N1 character.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset (also aborts a frame in flight)
//   bus   : slave side of tt_gear_status_tx_if
//           in  ena, led[6:0]; out tx, busy, gear_code[2:0], err
// ---------------------------------------------------------------------------
module tt_gear_status_tx
    import tt_gear_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 87,
    parameter int STABLE_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    tt_gear_status_tx_if.slave bus
);

    // Counter saturates at STABLE_CYCLES-1: that value before an edge means
    // led_q has been steady for STABLE_CYCLES cycles including this one.
    localparam int               STAB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_SAT = STAB_W'(STABLE_CYCLES - 1);

    logic [LED_W-1:0]  led_q;
    logic [STAB_W-1:0] stab_cnt;
    logic              stable;
    logic              accept;
    logic              report;
    gear_dec_t         dec;

    logic [GEAR_W-1:0] gear_code_q;
    logic              err_q;
    logic [GEAR_W-1:0] last_code;
    logic              pend_valid;
    logic [7:0]        pend_data;

    logic              uart_tx;
    logic              uart_busy;
    logic              uart_done;
    logic              uart_take;

    assign dec    = decode_gear(led_q);
    assign stable = (stab_cnt == STAB_SAT);
    // The counter keeps running while ena is low, so acceptance happens on
    // the first enabled cycle once the pattern has held long enough.
    assign accept = bus.ena && stable;
    assign report = accept && (dec.code != last_code);
    // The transmitter takes the pending byte when idle or on its final stop
    // cycle (back-to-back frames).
    assign uart_take = pend_valid && (!uart_busy || uart_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q       <= '0;
            stab_cnt    <= '0;
            gear_code_q <= GEAR_INV;
            err_q       <= 1'b1;
            last_code   <= GEAR_INV;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
        end else begin
            led_q <= bus.led;

            if (bus.led != led_q) stab_cnt <= '0;
            else if (!stable)     stab_cnt <= stab_cnt + STAB_W'(1);

            if (accept) begin
                gear_code_q <= dec.code;
                err_q       <= dec.err;
            end

            // A new report wins over the transmitter taking the old one, and
            // overwrites an unsent byte so only the latest gear is reported.
            if (report) begin
                pend_valid <= 1'b1;
                pend_data  <= ASCII_BASE + {5'b0, dec.code};
                last_code  <= dec.code;
            end else if (uart_take) begin
                pend_valid <= 1'b0;
            end
        end
    end

    tt_uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .start (pend_valid),
        .data  (pend_data),
        .tx    (uart_tx),
        .busy  (uart_busy),
        .done  (uart_done)
    );

    assign bus.tx        = uart_tx;
    assign bus.busy      = uart_busy;
    assign bus.gear_code = gear_code_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_tt_gear_status_tx.sv
// ---------------------------------------------------------------------------
// tb_tt_gear_status_tx
// Directed bench for tt_gear_status_tx with CLKS_PER_BIT=4, STABLE_CYCLES=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// Timing reference: led applied in the cycle after edge t, led_q captures it
// at t+1, gear_code updates at t+4, tx falls at t+5, a frame lasts 40 cycles.
// ---------------------------------------------------------------------------
module tb_tt_gear_status_tx;

    localparam int CPB   = 4;
    localparam int STAB  = 3;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst_n;

    tt_gear_status_tx_if bus ();

    tt_gear_status_tx #(
        .CLKS_PER_BIT (CPB),
        .STABLE_CYCLES(STAB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ena;
        logic [6:0] led;
        int         wait_cyc;
        int         exp_code;
        int         exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, then decodes one frame and checks its
    // shape. Returns positioned on the sample one frame length after the
    // first start-bit sample.
    task automatic rx_frame(input string tag, input int budget,
                            input logic [7:0] exp_byte, input bit expect_idle);
        int         n;
        int         busy_cnt;
        int         shape_bad;
        logic [7:0] rx;
        n = 0;
        while (bus.tx !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check({tag, " start bit seen"}, int'(bus.tx), 0);
        if (bus.tx !== 1'b0) return;
        busy_cnt  = 0;
        shape_bad = 0;
        rx        = '0;
        for (int off = 0; off < FRAME; off++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (off < CPB && bus.tx !== 1'b0) shape_bad++;
            if (off >= 9 * CPB && bus.tx !== 1'b1) shape_bad++;
            if (off >= CPB && off < 9 * CPB && (off % CPB) == 1)
                rx[(off - CPB) / CPB] = bus.tx;
            step(1);
        end
        check({tag, " byte"}, int'(rx), int'(exp_byte));
        check({tag, " busy cycles"}, busy_cnt, FRAME);
        check({tag, " start/stop shape"}, shape_bad, 0);
        if (expect_idle) begin
            check({tag, " busy after frame"}, int'(bus.busy), 0);
            check({tag, " tx after frame"}, int'(bus.tx), 1);
        end else begin
            check({tag, " back-to-back start"}, int'(bus.tx), 0);
        end
    endtask

    // Bounded wait for the line to stay idle 3 consecutive samples.
    task automatic wait_idle(input string tag, input int budget);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < budget) begin
            if (bus.busy === 1'b0) quiet++;
            else                   quiet = 0;
            step(1);
            n++;
        end
        check({tag, " line idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 7'b0000001, 5, 3, 0};  // D1
        vecs[1]  = '{1'b1, 7'b0000100, 5, 5, 0};  // D3
        vecs[2]  = '{1'b1, 7'b0001000, 5, 6, 0};  // D4
        vecs[3]  = '{1'b0, 7'b0010000, 5, 6, 0};  // P while disabled: blocked
        vecs[4]  = '{1'b1, 7'b0010000, 1, 0, 0};  // enable: accepted next edge
        vecs[5]  = '{1'b1, 7'b1000000, 5, 1, 0};  // R
        vecs[6]  = '{1'b1, 7'b0000000, 5, 7, 1};  // none lit
        vecs[7]  = '{1'b1, 7'b0100000, 5, 2, 0};  // N
        vecs[8]  = '{1'b1, 7'b1010000, 5, 7, 1};  // two lit
        vecs[9]  = '{1'b1, 7'b1111111, 5, 7, 1};  // all lit
        vecs[10] = '{1'b1, 7'b0000010, 5, 4, 0};  // D2

        // ---------------- reset, idle bus ----------------
        rst_n   = 1'b0;
        bus.ena = 1'b1;
        bus.led = 7'b0000000;
        step(3);
        check("reset tx", int'(bus.tx), 1);
        check("reset busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check($sformatf("idle tx c%0d", i), int'(bus.tx), 1);
            check($sformatf("idle busy c%0d", i), int'(bus.busy), 0);
        end
        check("idle gear_code", int'(bus.gear_code), 7);
        check("idle err", int'(bus.err), 1);

        // ---------------- P: exact latency, then R/D2 overwrite -----------
        bus.led = 7'b0010000;                 // applied after edge t
        step(1);                              // t+1
        check("P gear_code t+1", int'(bus.gear_code), 7);
        step(2);                              // t+3
        check("P gear_code t+3", int'(bus.gear_code), 7);
        step(1);                              // t+4
        check("P gear_code t+4", int'(bus.gear_code), 0);
        check("P err t+4", int'(bus.err), 0);
        check("P tx t+4", int'(bus.tx), 1);
        check("P busy t+4", int'(bus.busy), 0);
        step(1);                              // t+5
        check("P tx t+5", int'(bus.tx), 0);
        check("P busy t+5", int'(bus.busy), 1);
        fork
            begin
                rx_frame("P frame", 1, 8'h30, 1'b0);
                rx_frame("D2 frame", 1, 8'h34, 1'b1);
                for (int i = 0; i < 60; i++) begin
                    check($sformatf("after D2 tx c%0d", i), int'(bus.tx), 1);
                    step(1);
                end
            end
            begin
                step(8);
                bus.led = 7'b1000000;         // R, overwritten before sent
                step(5);
                check("R gear_code", int'(bus.gear_code), 1);
                bus.led = 7'b0000010;         // D2
                step(5);
                check("D2 gear_code", int'(bus.gear_code), 4);
                check("D2 err", int'(bus.err), 0);
            end
        join

        // ---------------- glitch inside steady N ----------------
        bus.led = 7'b0100000;
        rx_frame("N frame", 20, 8'h32, 1'b1);
        bus.led = 7'b1000000;                 // 2-cycle glitch
        step(2);
        bus.led = 7'b0100000;
        for (int i = 0; i < 60; i++) begin
            step(1);
            check($sformatf("glitch tx c%0d", i), int'(bus.tx), 1);
            check($sformatf("glitch gear_code c%0d", i), int'(bus.gear_code), 2);
        end

        // ---------------- decode table ----------------
        for (int i = 0; i < 11; i++) begin
            bus.ena = vecs[i].ena;
            bus.led = vecs[i].led;
            step(vecs[i].wait_cyc);
            check($sformatf("vec%0d gear_code", i), int'(bus.gear_code), vecs[i].exp_code);
            check($sformatf("vec%0d err", i), int'(bus.err), vecs[i].exp_err);
        end
        wait_idle("after table", 300);

        // ---------------- two LEDs lit -> '7' ----------------
        bus.led = 7'b0000011;
        rx_frame("invalid frame", 20, 8'h37, 1'b1);
        check("invalid gear_code", int'(bus.gear_code), 7);
        check("invalid err", int'(bus.err), 1);

        // ---------------- reset in the middle of a data bit ----------------
        bus.led = 7'b0100000;
        begin
            int n;
            n = 0;
            while (bus.tx !== 1'b0 && n < 20) begin
                step(1);
                n++;
            end
        end
        check("abort frame started", int'(bus.tx), 0);
        step(13);                             // middle of data bit 2
        rst_n = 1'b0;
        step(1);
        check("abort tx", int'(bus.tx), 1);
        check("abort busy", int'(bus.busy), 0);
        check("abort gear_code", int'(bus.gear_code), 7);
        check("abort err", int'(bus.err), 1);
        bus.led = 7'b0000000;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step(1);
            check($sformatf("post-abort tx c%0d", i), int'(bus.tx), 1);
            check($sformatf("post-abort busy c%0d", i), int'(bus.busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
